// File: rtl/spi_slave_egress_arbiter_pkg.sv
// Shared types and constants for the SPI egress arbiter.
// SPI_EGRESS_ARB_SRC_HEADER_EN enables the per-packet source header state.
package spi_egress_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        DATA = 2'd2
    } state_t;

    localparam logic [3:0] HDR_MARKER    = 4'hA;
    localparam logic [7:0] DEF_IDLE_BYTE = 8'h3C;

    // Grant index width; a single bit even for degenerate source counts.
    function automatic int calc_gw(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/spi_slave_egress_arbiter_if.sv
// AXI-Stream bundle: NUM_SRC byte producers in, one byte stream out.
interface spi_slave_egress_arbiter_if
    import spi_egress_arb_pkg::*;
#(
    parameter int NUM_SRC = 2,
    parameter int GW      = calc_gw(NUM_SRC)
);
    logic [NUM_SRC-1:0][7:0] s_axis_tdata;
    logic [NUM_SRC-1:0]      s_axis_tvalid;
    logic [NUM_SRC-1:0]      s_axis_tlast;
    logic [NUM_SRC-1:0]      s_axis_tready;
    logic [7:0]              m_axis_tdata;
    logic                    m_axis_tvalid;
    logic                    m_axis_tready;
    logic                    m_axis_tlast;
    logic [7:0]              m_axis_tuser;

    // master: the arbiter; slave: the producers and the egress FIFO around it
    modport master (
        input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
        output s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser
    );
    modport slave (
        output s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
        input  s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser
    );
endinterface

// File: rtl/spi_slave_egress_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req scanning upward from ptr+1.
module spi_egress_rr_pick
    import spi_egress_arb_pkg::*;
#(
    parameter int NUM_SRC = 2,
    parameter int GW      = calc_gw(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [GW-1:0]      ptr,
    output logic [GW-1:0]      gnt_idx,
    output logic               gnt_any
);
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        // Scan farthest-first so the nearest requester after ptr overwrites last.
        for (int i = NUM_SRC; i >= 1; i--) begin
            int idx;
            idx = (int'(ptr) + i) % NUM_SRC;
            if (req[idx]) begin
                gnt_any = 1'b1;
                gnt_idx = GW'(idx);
            end
        end
    end
endmodule

// File: rtl/spi_slave_egress_arbiter.sv
// Packet-granular round-robin arbiter feeding the SPI egress CDC FIFO.
// SPI_EGRESS_ARB_SRC_HEADER_EN prefixes each packet with {HDR_MARKER, grant_id}.
module spi_slave_egress_arbiter
    import spi_egress_arb_pkg::*;
#(
    parameter int          NUM_SRC       = 2,
    parameter int          MAX_PKT_BYTES = 256,
    parameter logic [7:0]  IDLE_BYTE     = DEF_IDLE_BYTE,
    localparam int         GW            = calc_gw(NUM_SRC)
) (
    input  logic                        clk,
    input  logic                        rst,
    spi_slave_egress_arbiter_if.master  bus,
    output logic [GW-1:0]               grant_id,
    output logic                        busy,
    output logic                        truncated
);
    localparam int CW = $clog2(MAX_PKT_BYTES);

    state_t        state;
    logic [CW-1:0] cnt;
    logic [GW-1:0] ptr;
    logic [GW-1:0] pick_idx;
    logic          pick_any;
    logic          g_vld, g_last, mtu_hit, beat, pkt_end;

    spi_egress_rr_pick #(.NUM_SRC(NUM_SRC), .GW(GW)) u_pick (
        .req     (bus.s_axis_tvalid),
        .ptr     (ptr),
        .gnt_idx (pick_idx),
        .gnt_any (pick_any)
    );

    assign bus.m_axis_tuser = IDLE_BYTE;

    assign g_vld   = bus.s_axis_tvalid[grant_id];
    assign g_last  = bus.s_axis_tlast[grant_id];
    assign mtu_hit = (cnt == CW'(MAX_PKT_BYTES - 1));
    assign beat    = (state == DATA) && g_vld && bus.m_axis_tready;
    assign pkt_end = beat && (g_last || mtu_hit);

    always_comb begin
        bus.m_axis_tdata  = '0;
        bus.m_axis_tvalid = 1'b0;
        bus.m_axis_tlast  = 1'b0;
        bus.s_axis_tready = '0;
        case (state)
`ifdef SPI_EGRESS_ARB_SRC_HEADER_EN
            HDR: begin
                bus.m_axis_tdata  = {HDR_MARKER, 4'(grant_id)};
                bus.m_axis_tvalid = 1'b1;
            end
`endif
            DATA: begin
                bus.m_axis_tdata            = bus.s_axis_tdata[grant_id];
                bus.m_axis_tvalid           = g_vld;
                bus.m_axis_tlast            = g_vld && (g_last || mtu_hit);
                bus.s_axis_tready[grant_id] = bus.m_axis_tready;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            grant_id  <= '0;
            busy      <= 1'b0;
            truncated <= 1'b0;
            cnt       <= '0;
            ptr       <= GW'(NUM_SRC - 1);
        end else begin
            truncated <= 1'b0;
            case (state)
                IDLE: if (pick_any) begin
                    grant_id <= pick_idx;
                    busy     <= 1'b1;
`ifdef SPI_EGRESS_ARB_SRC_HEADER_EN
                    state    <= HDR;
`else
                    state    <= DATA;
`endif
                end
`ifdef SPI_EGRESS_ARB_SRC_HEADER_EN
                HDR: if (bus.m_axis_tready) state <= DATA;
`endif
                DATA: if (pkt_end) begin
                    cnt       <= '0;
                    ptr       <= grant_id;
                    busy      <= 1'b0;
                    truncated <= mtu_hit && !g_last;
                    state     <= IDLE;
                end else if (beat) begin
                    cnt <= cnt + CW'(1);
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
